// File: rtl/sr_ctrl_pkg.sv
// Shared types, op encodings and width helpers for the sr_latch bank controller.
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StPulse,
      StGap
   } state_t;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_RST = 1'b0;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr, wrapping.
module rr_arbiter
   import sr_ctrl_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   localparam int unsigned IDW = clog2_min1(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);

   logic [IDW-1:0] k;
   logic           found;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      k      = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k = IDW'((32'(ptr) + i) % NREQ);
         if (en && !found && req[k]) begin
            gnt[k] = 1'b1;
            gnt_id = k;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sr_latch.sv
// Behavioural SR latch cell; the controller never drives s and r together.
module sr_latch (
   input  logic s,
   input  logic r,
   output logic q
);

   always_latch begin
      if (s) begin
         q <= 1'b1;
      end else if (r) begin
         q <= 1'b0;
      end
   end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Round-robin sequencer driving a shared sr_latch bank with pulse/gap timing and readback check.
module sr_latch_ctrl
   import sr_ctrl_pkg::*;
#(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned NLATCH = 8,
   parameter int unsigned PULSE  = 2,
   parameter int unsigned GAP    = 1,
   localparam int unsigned IW    = clog2_min1(NLATCH),
   localparam int unsigned IDW   = clog2_min1(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_op,
   input  logic [NREQ*IW-1:0]   req_idx,
   output logic [NREQ-1:0]      req_ready,
   output logic [NLATCH-1:0]    s,
   output logic [NLATCH-1:0]    r,
   input  logic [NLATCH-1:0]    q,
   output logic                 busy,
   output logic                 done,
   output logic [IDW-1:0]       done_id,
   output logic                 err
);

   localparam int unsigned CMAX = (PULSE > GAP) ? PULSE : GAP;
   localparam int unsigned CW   = clog2_min1(CMAX);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              op_q, op_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [NLATCH-1:0] s_q, s_d, r_q, r_d;
   logic              done_q, done_d;
   logic [IDW-1:0]    done_id_q, done_id_d;
   logic              err_q, err_d;

   logic [NREQ-1:0]   gnt;
   logic [IDW-1:0]    gnt_id;
   logic              win_op;
   logic [IW-1:0]     win_idx;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req    (req_valid),
      .ptr    (ptr_q),
      .en     (state_q == StIdle),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   always_comb begin
      win_op  = 1'b0;
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            win_op  = req_op[i];
            win_idx = req_idx[i*IW +: IW];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      idx_d     = idx_q;
      id_d      = id_q;
      ptr_d     = ptr_q;
      s_d       = s_q;
      r_d       = r_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      err_d     = err_q;

      unique case (state_q)
         StIdle: begin
            if (|gnt) begin
               op_d    = win_op;
               idx_d   = win_idx;
               id_d    = gnt_id;
               ptr_d   = (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
               cnt_d   = CW'(PULSE - 1);
               state_d = StPulse;
               // Out-of-range indices still run the full sequence, just with no line driven.
               if (32'(win_idx) < NLATCH) begin
                  s_d[win_idx] = (win_op == OP_SET);
                  r_d[win_idx] = (win_op == OP_RST);
               end
            end
         end
         StPulse: begin
            if (cnt_q == '0) begin
               s_d     = '0;
               r_d     = '0;
               cnt_d   = CW'(GAP - 1);
               state_d = StGap;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Entering the final gap cycle: flag completion and check the latch landed.
      if (state_d == StGap && cnt_d == '0) begin
         done_d    = 1'b1;
         done_id_d = id_q;
         if (32'(idx_q) < NLATCH && q[idx_q] != op_q) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_q      <= 1'b0;
         idx_q     <= '0;
         id_q      <= '0;
         ptr_q     <= '0;
         s_q       <= '0;
         r_q       <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         idx_q     <= idx_d;
         id_q      <= id_d;
         ptr_q     <= ptr_d;
         s_q       <= s_d;
         r_q       <= r_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         err_q     <= err_d;
      end
   end

   assign req_ready = gnt;
   assign s         = s_q;
   assign r         = r_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign err       = err_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a command-level model.
module tb_sr_latch_ctrl;

   localparam int unsigned NREQ   = 4;
   localparam int unsigned NLATCH = 6;
   localparam int unsigned PULSE  = 2;
   localparam int unsigned GAP    = 1;
   localparam int unsigned IW     = 3;
   localparam int unsigned IDW    = 2;
   localparam int          PG     = PULSE + GAP;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_op = '0;
   logic [NREQ*IW-1:0]  req_idx = '0;
   logic [NREQ-1:0]     req_ready;
   logic [NLATCH-1:0]   s, r, q, lat_q;
   logic [NLATCH-1:0]   force_mask = '0;
   logic                busy, done, err;
   logic [IDW-1:0]      done_id;

   always #5 clk = ~clk;

   assign q = lat_q & ~force_mask;

   sr_latch_ctrl #(
      .NREQ   (NREQ),
      .NLATCH (NLATCH),
      .PULSE  (PULSE),
      .GAP    (GAP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_idx   (req_idx),
      .req_ready (req_ready),
      .s         (s),
      .r         (r),
      .q         (q),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id),
      .err       (err)
   );

   for (genvar g = 0; g < NLATCH; g++) begin : g_lat
      sr_latch u_lat (
         .s (s[g]),
         .r (r[g]),
         .q (lat_q[g])
      );
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Requester-side stimulus
   logic [NREQ-1:0] v = '0;
   logic [NREQ-1:0] o = '0;
   logic [IW-1:0]   ix [NREQ];
   bit              keep = 1'b0;

   // Command-level model: m_k is the cycle number within the current command (0 = idle)
   int   m_k, m_ptr, m_id, m_idx, m_done_id;
   logic m_op, m_done, m_err;
   logic m_lat [NLATCH];
   int   glog[$];
   int   gcyc[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic m_reset();
      m_k       = 0;
      m_ptr     = 0;
      m_done    = 1'b0;
      m_err     = 1'b0;
      m_done_id = 0;
   endtask

   task automatic cycle();
      int w, dw;
      logic [NREQ-1:0]   exp_rdy;
      logic [NLATCH-1:0] es, er;
      req_valid = v;
      req_op    = o;
      for (int i = 0; i < NREQ; i++) req_idx[i*IW +: IW] = ix[i];
      #1;
      w = -1;
      if (m_k == 0) begin
         for (int j = 0; j < NREQ; j++) begin
            if (w < 0 && v[(m_ptr + j) % NREQ]) w = (m_ptr + j) % NREQ;
         end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
      dw = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i] && v[i]) dw = i;
      @(posedge clk);
      cyc++;
      if (dw >= 0) begin
         glog.push_back(dw);
         gcyc.push_back(cyc);
      end
      m_done = 1'b0;
      if (m_k != 0) begin
         m_k = (m_k == PG) ? 0 : m_k + 1;
      end else if (w >= 0) begin
         m_k   = 1;
         m_op  = o[w];
         m_idx = int'(ix[w]);
         m_id  = w;
         m_ptr = (w + 1) % NREQ;
         if (m_idx < NLATCH) m_lat[m_idx] = m_op;
         if (!keep) v[w] = 1'b0;
      end
      if (m_k == PG) begin
         m_done    = 1'b1;
         m_done_id = m_id;
         if (m_idx < NLATCH && ((force_mask[m_idx] ? 1'b0 : m_lat[m_idx]) != m_op)) m_err = 1'b1;
      end
      @(negedge clk);
      es = '0;
      er = '0;
      if (m_k >= 1 && m_k <= PULSE && m_idx < NLATCH) begin
         if (m_op) es[m_idx] = 1'b1;
         else er[m_idx] = 1'b1;
      end
      check_eq("s", 32'(s), 32'(es));
      check_eq("r", 32'(r), 32'(er));
      check_eq("s_and_r", 32'(s & r), 32'd0);
      check_eq("busy", 32'(busy), 32'(m_k != 0));
      check_eq("done", 32'(done), 32'(m_done));
      check_eq("err", 32'(err), 32'(m_err));
      if (m_done) begin
         check_eq("done_id", 32'(done_id), 32'(m_done_id));
         if (m_idx < NLATCH) check_eq("latch_q", 32'(lat_q[m_idx]), 32'(m_op));
      end
   endtask

   task automatic run_until_done(input int max, input string tag);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!m_done && n < max);
      check_eq(tag, 32'(done), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_s"}, 32'(s), 32'd0);
      check_eq({tag, "_r"}, 32'(r), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      check_eq({tag, "_err"}, 32'(err), 32'd0);
      check_eq({tag, "_done_id"}, 32'(done_id), 32'd0);
   endtask

   task automatic do_reset(input bit chk);
      rst_n     = 1'b0;
      v         = '0;
      req_valid = '0;
      m_reset();
      @(negedge clk);
      if (chk) begin
         check_idle_outputs("rst");
         check_eq("rst_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_req(input int i, input logic op, input int idx);
      v[i]  = 1'b1;
      o[i]  = op;
      ix[i] = IW'(idx);
   endtask

   initial begin
      int exp_rr [5];
      exp_rr = '{0, 1, 2, 3, 0};
      for (int i = 0; i < NREQ; i++) ix[i] = '0;
      for (int i = 0; i < NLATCH; i++) m_lat[i] = 1'b0;
      m_reset();

      // Reset values, then a single set of idx 3 from requester 0
      do_reset(1'b1);
      set_req(0, 1'b1, 3);
      run_until_done(8, "single_set_done");
      check_eq("single_set_q3", 32'(lat_q[3]), 32'd1);

      // All requesters valid continuously
      do_reset(1'b0);
      glog.delete();
      gcyc.delete();
      keep = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom), int'($urandom_range(0, NLATCH - 1)));
      for (int n = 0; n < 40 && glog.size() < 5; n++) cycle();
      keep = 1'b0;
      v    = '0;
      check_eq("rr_count", 32'(glog.size()), 32'd5);
      for (int i = 0; i < 5 && i < glog.size(); i++) check_eq("rr_order", 32'(glog[i]), 32'(exp_rr[i]));
      for (int i = 1; i < gcyc.size(); i++) check_eq("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'(1 + PG));
      repeat (PG + 1) cycle();

      // Async reset in the second pulse cycle of a command from requester 1
      set_req(1, 1'b1, 4);
      cycle();
      cycle();
      check_eq("midrst_s_before", 32'(s[4]), 32'd1);
      rst_n = 1'b0;
      #1;
      m_reset();
      check_idle_outputs("midrst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) cycle();

      // Same index, opposite ops; pointer is back at 0 so requester 1 goes first
      glog.delete();
      set_req(1, 1'b1, 5);
      set_req(2, 1'b0, 5);
      for (int n = 0; n < 20 && glog.size() < 2; n++) cycle();
      repeat (PG + 1) cycle();
      check_eq("contend_n", 32'(glog.size()), 32'd2);
      if (glog.size() >= 2) begin
         check_eq("contend_first", 32'(glog[0]), 32'd1);
         check_eq("contend_second", 32'(glog[1]), 32'd2);
      end
      check_eq("contend_q5", 32'(lat_q[5]), 32'd0);

      // Out-of-range index completes without driving lines or touching err
      set_req(0, 1'b1, 7);
      run_until_done(8, "oor_done");
      check_eq("oor_err", 32'(err), 32'd0);

      // Forced readback mismatch, then a good command
      force_mask[2] = 1'b1;
      set_req(0, 1'b1, 2);
      run_until_done(8, "err_done");
      check_eq("err_rise", 32'(err), 32'd1);
      repeat (2) cycle();
      force_mask = '0;
      set_req(3, 1'b0, 1);
      run_until_done(8, "err_good_done");
      check_eq("err_sticky", 32'(err), 32'd1);

      // Random traffic from a clean reset, including out-of-range indices
      do_reset(1'b0);
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!v[i] && $urandom_range(0, 2) == 0) set_req(i, 1'($urandom), int'($urandom_range(0, 7)));
         end
         cycle();
      end
      v = '0;
      repeat (PG + 2) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
